// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU ops, state and field encodings for the 16-bit CPU control unit
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_MUL  = 4'h6;
  localparam logic [3:0] OP_DIV  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_ILL  = 4'hF;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_XOR  = 3'd3;
  localparam logic [2:0] ALU_ADD  = 3'd4;
  localparam logic [2:0] ALU_SUB  = 3'd5;
  localparam logic [2:0] ALU_MUL  = 3'd6;
  localparam logic [2:0] ALU_DIV  = 3'd7;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RD_MSB    = 11;
  localparam int RD_LSB    = 8;
  localparam int RS_MSB    = 7;
  localparam int RS_LSB    = 4;
  localparam int RT_MSB    = 3;
  localparam int RT_LSB    = 0;
  localparam int IMM4_MSB  = 3;
  localparam int IMM12_MSB = 11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_BNE,
    CLS_JMP,
    CLS_HALT,
    CLS_ILL
  } inst_class_e;

  function automatic logic [15:0] sext4(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// rtl/cpu_decode.sv - combinational instruction decode: ALU controls, immediate, register addresses, class
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [15:0]  ir,
  output logic [2:0]   aluop,
  output logic         alusrc,
  output logic [15:0]  imm,
  output logic [3:0]   rs_addr,
  output logic [3:0]   rt_addr,
  output logic [3:0]   rd_addr,
  output inst_class_e  cls
);

  logic [3:0] op;
  assign op = ir[OP_MSB:OP_LSB];

  always_comb begin
    cls     = CLS_NOP;
    aluop   = ALU_NONE;
    alusrc  = 1'b0;
    imm     = '0;
    rs_addr = '0;
    rt_addr = '0;
    rd_addr = '0;
    case (op)
      OP_NOP: cls = CLS_NOP;
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
        cls     = CLS_ALU;
        aluop   = op[2:0];
        rd_addr = ir[RD_MSB:RD_LSB];
        rs_addr = ir[RS_MSB:RS_LSB];
        rt_addr = ir[RT_MSB:RT_LSB];
      end
      OP_ADDI, OP_LW: begin
        cls     = (op == OP_LW) ? CLS_LOAD : CLS_ALU;
        aluop   = ALU_ADD;
        alusrc  = 1'b1;
        imm     = sext4(ir[IMM4_MSB:0]);
        rd_addr = ir[RD_MSB:RD_LSB];
        rs_addr = ir[RS_MSB:RS_LSB];
      end
      OP_SW: begin
        // Store data comes from the rd field, read through port B.
        cls     = CLS_STORE;
        aluop   = ALU_ADD;
        alusrc  = 1'b1;
        imm     = sext4(ir[IMM4_MSB:0]);
        rs_addr = ir[RS_MSB:RS_LSB];
        rt_addr = ir[RD_MSB:RD_LSB];
      end
      OP_BEQ, OP_BNE: begin
        cls     = (op == OP_BEQ) ? CLS_BEQ : CLS_BNE;
        aluop   = ALU_SUB;
        imm     = sext4(ir[IMM4_MSB:0]);
        rs_addr = ir[RS_MSB:RS_LSB];
        rt_addr = ir[RD_MSB:RD_LSB];
      end
      OP_JMP:  cls = CLS_JMP;
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multi-cycle fetch/decode/exec/mem/wb control unit with PC and handshake timeout
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc_out,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] instr_in,
  output logic [2:0]  aluop,
  output logic        alusrc,
  output logic [15:0] imm_out,
  input  logic        alu_zero,
  output logic [3:0]  rs_addr,
  output logic [3:0]  rt_addr,
  output logic [3:0]  rd_addr,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err
);

  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  state_e      state;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] wait_cnt;
  logic        imem_req_q;
  logic        dmem_req_q;
  logic        timeout_hit;

  logic [2:0]  dec_aluop;
  logic        dec_alusrc;
  logic [15:0] dec_imm;
  inst_class_e cls;

  cpu_decode u_decode (
    .ir      (ir),
    .aluop   (dec_aluop),
    .alusrc  (dec_alusrc),
    .imm     (dec_imm),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rd_addr (rd_addr),
    .cls     (cls)
  );

  // Gating with rst_n drops requests in the same instant reset asserts.
  assign imem_req    = imem_req_q & rst_n;
  assign dmem_req    = dmem_req_q & rst_n;
  assign pc_out      = pc;
  assign timeout_hit = (ACK_TIMEOUT != 0) && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      wait_cnt   <= '0;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we    <= 1'b0;
      reg_write  <= 1'b0;
      wb_sel     <= 1'b0;
      aluop      <= ALU_NONE;
      alusrc     <= 1'b0;
      imm_out    <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir         <= instr_in;
            pc         <= pc + 16'd1;
            wait_cnt   <= '0;
            imem_req_q <= 1'b0;
            state      <= S_DECODE;
          end else if (timeout_hit) begin
            wait_cnt   <= '0;
            imem_req_q <= 1'b0;
            bus_err    <= 1'b1;
            halted     <= 1'b1;
            state      <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_DECODE: begin
          if (cls == CLS_ILL || cls == CLS_HALT) begin
            if (cls == CLS_ILL) illegal <= 1'b1;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            aluop   <= dec_aluop;
            alusrc  <= dec_alusrc;
            imm_out <= dec_imm;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls)
            CLS_ALU: begin
              reg_write <= 1'b1;
              wb_sel    <= 1'b0;
              state     <= S_WB;
            end
            CLS_LOAD: begin
              dmem_req_q <= 1'b1;
              state      <= S_MEM;
            end
            CLS_STORE: begin
              dmem_req_q <= 1'b1;
              dmem_we    <= 1'b1;
              state      <= S_MEM;
            end
            default: begin
              // pc already points past this instruction, so offsets are relative to pc+1.
              if ((cls == CLS_BEQ && alu_zero) || (cls == CLS_BNE && !alu_zero))
                pc <= pc + imm_out;
              else if (cls == CLS_JMP)
                pc <= {pc[15:12], ir[IMM12_MSB:0]};
              imem_req_q <= 1'b1;
              aluop      <= ALU_NONE;
              alusrc     <= 1'b0;
              imm_out    <= '0;
              state      <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we    <= 1'b0;
            wait_cnt   <= '0;
            if (cls == CLS_LOAD) begin
              reg_write <= 1'b1;
              wb_sel    <= 1'b1;
              state     <= S_WB;
            end else begin
              imem_req_q <= 1'b1;
              aluop      <= ALU_NONE;
              alusrc     <= 1'b0;
              imm_out    <= '0;
              state      <= S_FETCH;
            end
          end else if (timeout_hit) begin
            dmem_req_q <= 1'b0;
            dmem_we    <= 1'b0;
            wait_cnt   <= '0;
            aluop      <= ALU_NONE;
            alusrc     <= 1'b0;
            imm_out    <= '0;
            bus_err    <= 1'b1;
            halted     <= 1'b1;
            state      <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_WB: begin
          wb_sel     <= 1'b0;
          imem_req_q <= 1'b1;
          aluop      <= ALU_NONE;
          alusrc     <= 1'b0;
          imm_out    <= '0;
          state      <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: begin
          halted <= 1'b1;
          state  <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - directed self-checking bench for cpu_control_fsm
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_out;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] instr_in;
  logic [2:0]  aluop;
  logic        alusrc;
  logic [15:0] imm_out;
  logic        alu_zero;
  logic [3:0]  rs_addr;
  logic [3:0]  rt_addr;
  logic [3:0]  rd_addr;
  logic        reg_write;
  logic        wb_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        halted;
  logic        illegal;
  logic        bus_err;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  cpu_control_fsm #(
    .RESET_PC    (16'h0000),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_out    (pc_out),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .instr_in  (instr_in),
    .aluop     (aluop),
    .alusrc    (alusrc),
    .imm_out   (imm_out),
    .alu_zero  (alu_zero),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .halted    (halted),
    .illegal   (illegal),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [15:0] instr);
    imem_ack = 1'b1;
    instr_in = instr;
    step();
    imem_ack = 1'b0;
    instr_in = 16'h0000;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    instr_in = 16'h0000;
    alu_zero = 1'b0;
    dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_imem_req", 16'(imem_req), 16'h0000);
    chk("rst_dmem_req", 16'(dmem_req), 16'h0000);
    chk("rst_reg_write", 16'(reg_write), 16'h0000);
    chk("rst_aluop", 16'(aluop), 16'h0000);
    chk("rst_flags", 16'({halted, illegal, bus_err}), 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("fetch_req", 16'(imem_req), 16'h0001);

    // R-type AND r1 = r2 & r3
    fetch(16'h1123);
    chk("r_rs", 16'(rs_addr), 16'h0002);
    chk("r_rt", 16'(rt_addr), 16'h0003);
    chk("r_dec_rw", 16'(reg_write), 16'h0000);
    step();
    chk("r_aluop", 16'(aluop), 16'h0001);
    chk("r_alusrc", 16'(alusrc), 16'h0000);
    step();
    chk("r_rw", 16'(reg_write), 16'h0001);
    chk("r_rd", 16'(rd_addr), 16'h0001);
    chk("r_wbsel", 16'(wb_sel), 16'h0000);
    step();
    chk("r_rw_end", 16'(reg_write), 16'h0000);
    chk("r_pc", pc_out, 16'h0001);
    chk("r_aluop_fetch", 16'(aluop), 16'h0000);
    chk("r_imem_req", 16'(imem_req), 16'h0001);

    // ADDI r1 = r2 + (-1)
    fetch(16'h812F);
    step();
    chk("addi_aluop", 16'(aluop), 16'h0004);
    chk("addi_alusrc", 16'(alusrc), 16'h0001);
    chk("addi_imm", imm_out, 16'hFFFF);
    step();
    chk("addi_rw", 16'(reg_write), 16'h0001);
    chk("addi_wbsel", 16'(wb_sel), 16'h0000);
    step();
    chk("addi_pc", pc_out, 16'h0002);

    // LW r3 = mem[r4+1], dmem_ack in third MEM cycle, stray imem_ack ignored
    fetch(16'h9341);
    step();
    chk("lw_imm", imm_out, 16'h0001);
    step();
    chk("lw_mem1_req", 16'(dmem_req), 16'h0001);
    chk("lw_mem1_we", 16'(dmem_we), 16'h0000);
    imem_ack = 1'b1;
    instr_in = 16'hE000;
    step();
    imem_ack = 1'b0;
    instr_in = 16'h0000;
    chk("lw_mem2_req", 16'(dmem_req), 16'h0001);
    chk("lw_stray_halt", 16'(halted), 16'h0000);
    step();
    chk("lw_mem3_req", 16'(dmem_req), 16'h0001);
    chk("lw_mem3_rw", 16'(reg_write), 16'h0000);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("lw_wb_req", 16'(dmem_req), 16'h0000);
    chk("lw_wb_rw", 16'(reg_write), 16'h0001);
    chk("lw_wb_sel", 16'(wb_sel), 16'h0001);
    chk("lw_wb_rd", 16'(rd_addr), 16'h0003);
    step();
    chk("lw_end_rw", 16'(reg_write), 16'h0000);
    chk("lw_end_sel", 16'(wb_sel), 16'h0000);
    chk("lw_pc", pc_out, 16'h0003);

    // SW mem[r4+1] = r3
    fetch(16'hA341);
    chk("sw_rt", 16'(rt_addr), 16'h0003);
    chk("sw_rs", 16'(rs_addr), 16'h0004);
    step();
    step();
    chk("sw_req", 16'(dmem_req), 16'h0001);
    chk("sw_we", 16'(dmem_we), 16'h0001);
    chk("sw_mem_rw", 16'(reg_write), 16'h0000);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("sw_end_req", 16'(dmem_req), 16'h0000);
    chk("sw_end_we", 16'(dmem_we), 16'h0000);
    chk("sw_end_rw", 16'(reg_write), 16'h0000);
    chk("sw_pc", pc_out, 16'h0004);

    // JMP to 0x010, then branches around it
    fetch(16'hD010);
    step();
    chk("jmp_aluop", 16'(aluop), 16'h0000);
    step();
    chk("jmp_pc", pc_out, 16'h0010);

    fetch(16'hB12E);
    step();
    chk("beq_aluop", 16'(aluop), 16'h0005);
    chk("beq_alusrc", 16'(alusrc), 16'h0000);
    chk("beq_imm", imm_out, 16'hFFFE);
    alu_zero = 1'b1;
    step();
    alu_zero = 1'b0;
    chk("beq_taken_pc", pc_out, 16'h000F);

    fetch(16'hD010);
    step();
    step();
    fetch(16'hB12E);
    step();
    step();
    chk("beq_not_taken_pc", pc_out, 16'h0011);

    fetch(16'hC12E);
    step();
    step();
    chk("bne_taken_pc", pc_out, 16'h0010);

    fetch(16'hC12E);
    step();
    alu_zero = 1'b1;
    step();
    alu_zero = 1'b0;
    chk("bne_not_taken_pc", pc_out, 16'h0011);

    // Cross into page 1 by incrementing past 0x0FFF, then page-relative jumps
    fetch(16'hDFFF);
    step();
    step();
    chk("jmp_fff_pc", pc_out, 16'h0FFF);
    fetch(16'h0000);
    step();
    chk("nop_aluop", 16'(aluop), 16'h0000);
    step();
    chk("nop_pc_wrap_page", pc_out, 16'h1000);
    fetch(16'hD230);
    step();
    step();
    chk("jmp_1230_pc", pc_out, 16'h1230);
    fetch(16'hD0A5);
    step();
    step();
    chk("jmp_10a5_pc", pc_out, 16'h10A5);

    // Fetch timeout: four wait cycles with no imem_ack
    step();
    step();
    step();
    chk("to_pre_bus_err", 16'(bus_err), 16'h0000);
    chk("to_pre_req", 16'(imem_req), 16'h0001);
    step();
    chk("to_bus_err", 16'(bus_err), 16'h0001);
    chk("to_halted", 16'(halted), 16'h0001);
    chk("to_req", 16'(imem_req), 16'h0000);
    imem_ack = 1'b1;
    instr_in = 16'h1123;
    step();
    step();
    imem_ack = 1'b0;
    instr_in = 16'h0000;
    chk("halt_hold_pc", pc_out, 16'h10A5);
    chk("halt_hold_req", 16'(imem_req), 16'h0000);

    // HALT instruction
    reset_dut();
    chk("rst2_bus_err", 16'(bus_err), 16'h0000);
    chk("rst2_halted", 16'(halted), 16'h0000);
    chk("rst2_pc", pc_out, 16'h0000);
    fetch(16'hE000);
    step();
    chk("halt_halted", 16'(halted), 16'h0001);
    chk("halt_illegal", 16'(illegal), 16'h0000);
    chk("halt_req", 16'(imem_req), 16'h0000);
    step();
    step();
    chk("halt_req_later", 16'(imem_req), 16'h0000);
    chk("halt_pc", pc_out, 16'h0001);

    // Illegal opcode
    reset_dut();
    fetch(16'hF000);
    step();
    chk("ill_illegal", 16'(illegal), 16'h0001);
    chk("ill_halted", 16'(halted), 16'h0001);
    chk("ill_bus_err", 16'(bus_err), 16'h0000);

    // Reset during MEM wait
    reset_dut();
    fetch(16'h9341);
    step();
    step();
    chk("abort_pre_req", 16'(dmem_req), 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_dmem_req", 16'(dmem_req), 16'h0000);
    chk("abort_rw", 16'(reg_write), 16'h0000);
    chk("abort_imem_req", 16'(imem_req), 16'h0000);
    chk("abort_pc", pc_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart_req", 16'(imem_req), 16'h0001);
    chk("restart_pc", pc_out, 16'h0000);
    chk("restart_rw", 16'(reg_write), 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control unit for the 16-bit CPU. It sits on the other end of the ALU control interface: it fetches and decodes instructions, drives aluop/alusrc/immediate into the ALU, and consumes the ALU zero flag for branches. It also sequences register-file writeback and the instruction and data memory handshakes.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset (word address)
ACK_TIMEOUT, 255, max cycles waiting for imem_ack/dmem_ack before bus error; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_out  out  16  instruction fetch address
imem_req  out  1  instruction fetch request
imem_ack  in  1  instruction valid on instr_in this cycle
instr_in  in  16  fetched instruction
aluop  out  3  ALU operation: 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 MUL, 7 DIV
alusrc  out  1  1 selects immediate as ALU operand 2
imm_out  out  16  sign-extended immediate to ALU
alu_zero  in  1  ALU zero flag
rs_addr  out  4  register-file read port A
rt_addr  out  4  register-file read port B
rd_addr  out  4  register-file write address
reg_write  out  1  register-file write strobe (one cycle)
wb_sel  out  1  0 writes ALU result, 1 writes load data
dmem_req  out  1  data memory request; address is the ALU result
dmem_we  out  1  data memory write (valid while dmem_req is high)
dmem_ack  in  1  data memory transfer complete
halted  out  1  core stopped
illegal  out  1  sticky: illegal opcode
bus_err  out  1  sticky: handshake timeout

Behaviour:
- Instruction formats: op=[15:12].
  - R: rd=[11:8], rs=[7:4], rt=[3:0].
  - I: rd=[11:8], rs=[7:4], imm4=[3:0], sign-extended to 16 bits.
  - J: imm12=[11:0].
- Opcodes:
  - 0 NOP.
  - 1–7 R-type: aluop=op[2:0], alusrc=0.
  - 8 ADDI: aluop=4, alusrc=1.
  - 9 LW: rd <= mem[rs+imm].
  - A SW: mem[rs+imm] <= reg[rd]; rt_addr=rd.
  - B BEQ, C BNE: compare reg[rd] vs reg[rs] with SUB, alusrc=0; branch offset=imm4.
  - D JMP: pc <= {pc[15:12], imm12}.
  - E HALT.
  - F illegal.
- States and transitions:
  - FETCH: imem_req=1, pc_out=pc.
    - On imem_ack: ir <= instr_in, pc <= pc+1 (16-bit wrap), go to DECODE.
  - DECODE (1 cycle): register addresses and imm_out become valid.
    - 0xF: set illegal, go to HALT.
    - 0xE: go to HALT.
    - Otherwise go to EXEC.
  - EXEC (1 cycle): sample alu_zero.
    - BEQ taken if zero=1; BNE taken if zero=0. Taken: pc <= pc + imm_out.
    - JMP: load pc.
    - R/ADDI go to WB. LW/SW go to MEM. NOP/branch/JMP go to FETCH.
  - MEM: dmem_req=1; dmem_we=1 for SW.
    - On dmem_ack: LW goes to WB, SW goes to FETCH.
  - WB (1 cycle): reg_write=1; wb_sel=1 for LW, else 0. Then go to FETCH.
  - HALT: halted=1, imem_req=0. The block stays here until reset.
- Output stability: aluop, alusrc and imm_out are registered from ir on leaving DECODE and held stable through EXEC, MEM and WB. This keeps the ALU result valid for address and writeback. aluop is 0 in FETCH/HALT and for NOP/JMP.
- Latency with ack in the first request cycle:
  - R/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch/JMP/NOP: 3 cycles.
- Timeout: a wait counter runs in FETCH/MEM while ack is low. When it reaches ACK_TIMEOUT: set bus_err, go to HALT. The counter clears on ack or state change.
- imem_ack or dmem_ack asserted outside the matching request state is ignored.
- Reset values: pc=RESET_PC, state=FETCH, ir=0. All other outputs 0 (except pc_out=RESET_PC).
- Reset asserted mid-operation aborts immediately. Outstanding requests drop combinationally with rst_n low. No write strobe is issued.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_NOP..OP_ILL),
  - ALU op constants (ALU_AND..ALU_DIV),
  - state encoding,
  - field position constants.
- One sub-module, cpu_decode: combinational ir -> {aluop, alusrc, imm_out, register addresses, instruction class}.
- The FSM, PC and timeout counter stay in cpu_control_fsm.

Test Plan:
- Reset: rst_n low → pc_out=0000, all strobes 0. Release, then instr 0x1123 with ack in the first cycle → aluop=1, alusrc=0, rs=2, rt=3. reg_write pulses in cycle 4 with rd=1.
- ADDI 0x812F → aluop=4, alusrc=1, imm_out=FFFF, wb_sel=0.
- LW 0x9341 with dmem_ack delayed 3 cycles → dmem_req held 3 cycles with dmem_we=0, then reg_write with wb_sel=1, rd=3. SW 0xA341 → dmem_we=1, no reg_write.
- BEQ 0xB12E at pc=0010 with alu_zero=1 → next fetch at 000F. With alu_zero=0 → next fetch at 0011. BNE 0xC12E inverts both. JMP 0xD0A5 at pc=1230 → next fetch at 10A5.
- HALT 0xE000 → halted=1, no further imem_req. Opcode 0xF000 → illegal=1, halted=1. ACK_TIMEOUT=4 with imem_ack never asserted → bus_err=1 after 4 wait cycles.
- rst_n pulsed low during MEM wait → dmem_req drops immediately, no reg_write, fetch restarts at RESET_PC.
